// File: rtl/dsi_cfg_pkg.sv
// rtl/dsi_cfg_pkg.sv - shared types and constants for the DSI configuration-port arbiter
package dsi_cfg_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WADDR,
      S_WRESP,
      S_RADDR,
      S_RDATA,
      S_DONE
   } cfg_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int DEF_ADDR_W  = 7;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 1023;

   // Only the two error codes flag a failed access; OKAY and EXOKAY both succeed.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage

// File: rtl/dsi_cfg_rr_arb.sv
// rtl/dsi_cfg_rr_arb.sv - two-way round-robin arbiter with registered last-grant pointer
module dsi_cfg_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant
);

   // last = 1 means requester 1 won most recently, so requester 0 is favoured after reset
   logic last;

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= 1'b1;
      end else if (update) begin
         last <= grant[1];
      end
   end

endmodule

// File: rtl/dsi_cfg_arbiter.sv
// rtl/dsi_cfg_arbiter.sv - req/ack to AXI4-Lite bridge shared by init and runtime requesters; DSI_CFG_VBLANK_GATE_EN gates requester 1 to vblank
module dsi_cfg_arbiter
   import dsi_cfg_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                  i_axi_clk,
   input  logic                  i_arst,
   input  logic [1:0]            i_req,
   input  logic [1:0]            i_we,
   input  logic [2*ADDR_W-1:0]   i_addr,
   input  logic [2*DATA_W-1:0]   i_wdata,
   output logic [1:0]            o_ack,
   output logic [DATA_W-1:0]     o_rdata,
   output logic                  o_err,
   output logic                  o_timeout,
   input  logic                  i_vs,
   output logic [ADDR_W-1:0]     o_axi_awaddr,
   output logic                  o_axi_awvalid,
   input  logic                  i_axi_awready,
   output logic [DATA_W-1:0]     o_axi_wdata,
   output logic                  o_axi_wvalid,
   input  logic                  i_axi_wready,
   input  logic                  i_axi_bvalid,
   input  logic [1:0]            i_axi_bresp,
   output logic                  o_axi_bready,
   output logic [ADDR_W-1:0]     o_axi_araddr,
   output logic                  o_axi_arvalid,
   input  logic                  i_axi_arready,
   input  logic [DATA_W-1:0]     i_axi_rdata,
   input  logic [1:0]            i_axi_rresp,
   input  logic                  i_axi_rvalid,
   output logic                  o_axi_rready
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   cfg_state_t        state;
   logic [1:0]        gnt;
   logic [CNT_W-1:0]  cnt;
   logic              vs_meta;
   logic              vs_sync;
   logic [1:0]        eligible;
   logic [1:0]        arb_grant;
   logic              busy;
   logic              timeout_hit;
   logic              sel;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   always_ff @(posedge i_axi_clk or posedge i_arst) begin
      if (i_arst) begin
         vs_meta <= 1'b0;
         vs_sync <= 1'b0;
      end else begin
         vs_meta <= i_vs;
         vs_sync <= vs_meta;
      end
   end

`ifdef DSI_CFG_VBLANK_GATE_EN
   assign eligible = {i_req[1] & vs_sync, i_req[0]};
`else
   logic unused_vs;
   assign unused_vs = vs_sync;
   assign eligible  = i_req;
`endif

   dsi_cfg_rr_arb u_rr_arb (
      .clk    (i_axi_clk),
      .rst    (i_arst),
      .req    (eligible),
      .update ((state == S_IDLE) && (|eligible)),
      .grant  (arb_grant)
   );

   assign sel       = arb_grant[1];
   assign sel_we    = i_we[sel];
   assign sel_addr  = sel ? i_addr[2*ADDR_W-1:ADDR_W] : i_addr[ADDR_W-1:0];
   assign sel_wdata = sel ? i_wdata[2*DATA_W-1:DATA_W] : i_wdata[DATA_W-1:0];

   assign busy        = (state == S_WADDR) || (state == S_WRESP) ||
                        (state == S_RADDR) || (state == S_RDATA);
   assign timeout_hit = (TIMEOUT != 0) && busy && (cnt == CNT_LAST);

   always_ff @(posedge i_axi_clk or posedge i_arst) begin
      if (i_arst) begin
         state         <= S_IDLE;
         gnt           <= '0;
         cnt           <= '0;
         o_ack         <= '0;
         o_rdata       <= '0;
         o_err         <= 1'b0;
         o_timeout     <= 1'b0;
         o_axi_awaddr  <= '0;
         o_axi_awvalid <= 1'b0;
         o_axi_wdata   <= '0;
         o_axi_wvalid  <= 1'b0;
         o_axi_bready  <= 1'b0;
         o_axi_araddr  <= '0;
         o_axi_arvalid <= 1'b0;
         o_axi_rready  <= 1'b0;
      end else begin
         o_ack <= '0;
         cnt   <= busy ? cnt + 1'b1 : '0;
         case (state)
            S_IDLE: begin
               if (|eligible) begin
                  gnt <= arb_grant;
                  if (sel_we) begin
                     o_axi_awaddr  <= sel_addr;
                     o_axi_wdata   <= sel_wdata;
                     o_axi_awvalid <= 1'b1;
                     o_axi_wvalid  <= 1'b1;
                     state         <= S_WADDR;
                  end else begin
                     o_axi_araddr  <= sel_addr;
                     o_axi_arvalid <= 1'b1;
                     state         <= S_RADDR;
                  end
               end
            end
            S_WADDR: begin
               // AW and W complete independently; leave only once both have handshaken
               if (i_axi_awready) o_axi_awvalid <= 1'b0;
               if (i_axi_wready)  o_axi_wvalid  <= 1'b0;
               if ((!o_axi_awvalid || i_axi_awready) && (!o_axi_wvalid || i_axi_wready)) begin
                  o_axi_bready <= 1'b1;
                  state        <= S_WRESP;
               end
            end
            S_WRESP: begin
               if (i_axi_bvalid) begin
                  o_axi_bready <= 1'b0;
                  o_err        <= resp_is_err(i_axi_bresp);
                  o_rdata      <= '0;
                  o_ack        <= gnt;
                  state        <= S_DONE;
               end
            end
            S_RADDR: begin
               if (i_axi_arready) begin
                  o_axi_arvalid <= 1'b0;
                  o_axi_rready  <= 1'b1;
                  state         <= S_RDATA;
               end
            end
            S_RDATA: begin
               if (i_axi_rvalid) begin
                  o_axi_rready <= 1'b0;
                  o_rdata      <= i_axi_rdata;
                  o_err        <= resp_is_err(i_axi_rresp);
                  o_ack        <= gnt;
                  state        <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
         // An expired timeout overrides whatever the channel logic decided this cycle
         if (timeout_hit) begin
            o_axi_awvalid <= 1'b0;
            o_axi_wvalid  <= 1'b0;
            o_axi_bready  <= 1'b0;
            o_axi_arvalid <= 1'b0;
            o_axi_rready  <= 1'b0;
            o_timeout     <= 1'b1;
            o_err         <= 1'b1;
            o_rdata       <= '0;
            o_ack         <= gnt;
            state         <= S_DONE;
         end
      end
   end

endmodule

// File: tb/tb_dsi_cfg_arbiter.sv
// tb/tb_dsi_cfg_arbiter.sv - scoreboard bench for dsi_cfg_arbiter with a behavioural AXI4-Lite slave
module tb_dsi_cfg_arbiter;

   localparam int AW = 7;
   localparam int DW = 32;

   typedef struct {
      logic        we;
      logic        tmo;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        r_req   [2];
   logic        r_we    [2];
   logic [6:0]  r_addr  [2];
   logic [31:0] r_wdata [2];

   logic [1:0]      i_req;
   logic [1:0]      i_we;
   logic [2*AW-1:0] i_addr;
   logic [2*DW-1:0] i_wdata;
   assign i_req   = {r_req[1], r_req[0]};
   assign i_we    = {r_we[1], r_we[0]};
   assign i_addr  = {r_addr[1], r_addr[0]};
   assign i_wdata = {r_wdata[1], r_wdata[0]};

   logic [1:0]    o_ack;
   logic [DW-1:0] o_rdata;
   logic          o_err, o_timeout, i_vs;
   logic [AW-1:0] o_axi_awaddr, o_axi_araddr;
   logic [DW-1:0] o_axi_wdata, s_rdata;
   logic          o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid, o_axi_rready;
   logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
   logic [1:0]    s_bresp, s_rresp;

   dsi_cfg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
      .i_axi_clk     (clk),
      .i_arst        (rst),
      .i_req         (i_req),
      .i_we          (i_we),
      .i_addr        (i_addr),
      .i_wdata       (i_wdata),
      .o_ack         (o_ack),
      .o_rdata       (o_rdata),
      .o_err         (o_err),
      .o_timeout     (o_timeout),
      .i_vs          (i_vs),
      .o_axi_awaddr  (o_axi_awaddr),
      .o_axi_awvalid (o_axi_awvalid),
      .i_axi_awready (s_awready),
      .o_axi_wdata   (o_axi_wdata),
      .o_axi_wvalid  (o_axi_wvalid),
      .i_axi_wready  (s_wready),
      .i_axi_bvalid  (s_bvalid),
      .i_axi_bresp   (s_bresp),
      .o_axi_bready  (o_axi_bready),
      .o_axi_araddr  (o_axi_araddr),
      .o_axi_arvalid (o_axi_arvalid),
      .i_axi_arready (s_arready),
      .i_axi_rdata   (s_rdata),
      .i_axi_rresp   (s_rresp),
      .i_axi_rvalid  (s_rvalid),
      .o_axi_rready  (o_axi_rready)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int t0 [2];
   exp_t q0[$];
   exp_t q1[$];
   int ack_log[$];
   int n_ack1    = 0;
   int n_bfire   = 0;
   int n_wr_done = 0;
   logic [31:0] mem [32];
   logic [31:0] mdl [32];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // ---------------- behavioural AXI4-Lite slave ----------------
   bit rand_delays = 0;
   bit b_hang = 0;
   int cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0;
   bit aw_seen, aw_done, w_seen, w_done, b_seen, ar_seen, ar_done, r_seen, b_fire, r_fire;
   int aw_wait, w_wait, b_wait, ar_wait, r_wait;
   logic [6:0]  aw_a, ar_a;
   logic [31:0] w_d;

   function automatic int pick(input int fixed, input int mx);
      if (rand_delays) return int'($urandom_range(mx, 0));
      return fixed;
   endfunction

   function automatic logic is_err_addr(input logic [6:0] a);
      return a[5:2] == 4'hF;
   endfunction

   task automatic slave_clear();
      {s_awready, s_wready, s_bvalid, s_arready, s_rvalid} = '0;
      s_bresp = 2'b00; s_rresp = 2'b00; s_rdata = '0;
      {aw_seen, aw_done, w_seen, w_done, b_seen, ar_seen, ar_done, r_seen, b_fire, r_fire} = '0;
   endtask

   initial begin
      slave_clear();
      forever begin
         @(negedge clk);
         if (rst) begin
            slave_clear();
            continue;
         end
         if (b_fire) begin
            if (!is_err_addr(aw_a)) mem[aw_a[6:2]] = w_d;
            n_bfire++;
            s_bvalid = 0;
            {aw_seen, aw_done, w_seen, w_done, b_seen} = '0;
         end
         if (r_fire) begin
            s_rvalid = 0;
            {ar_seen, ar_done, r_seen} = '0;
         end
         if (aw_done && w_done && !s_bvalid && !b_hang) begin
            if (!b_seen) begin b_seen = 1; b_wait = pick(cfg_b, 2); end
            if (b_wait == 0) begin
               s_bvalid = 1;
               s_bresp  = is_err_addr(aw_a) ? 2'b10 : 2'b00;
            end else b_wait--;
         end
         if (ar_done && !s_rvalid) begin
            if (!r_seen) begin r_seen = 1; r_wait = pick(cfg_r, 2); end
            if (r_wait == 0) begin
               s_rvalid = 1;
               s_rdata  = mem[ar_a[6:2]];
               s_rresp  = is_err_addr(ar_a) ? 2'b10 : 2'b00;
            end else r_wait--;
         end
         s_awready = 0;
         if (o_axi_awvalid && !aw_done) begin
            if (!aw_seen) begin aw_seen = 1; aw_wait = pick(cfg_aw, 2); end
            if (aw_wait == 0) begin s_awready = 1; aw_done = 1; aw_a = o_axi_awaddr; end
            else aw_wait--;
         end
         s_wready = 0;
         if (o_axi_wvalid && !w_done) begin
            if (!w_seen) begin w_seen = 1; w_wait = pick(cfg_w, 2); end
            if (w_wait == 0) begin s_wready = 1; w_done = 1; w_d = o_axi_wdata; end
            else w_wait--;
         end
         s_arready = 0;
         if (o_axi_arvalid && !ar_done) begin
            if (!ar_seen) begin ar_seen = 1; ar_wait = pick(cfg_ar, 1); end
            if (ar_wait == 0) begin s_arready = 1; ar_done = 1; ar_a = o_axi_araddr; end
            else ar_wait--;
         end
         b_fire = s_bvalid && o_axi_bready;
         r_fire = s_rvalid && o_axi_rready;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && o_ack != 2'b00) begin
            int n;
            exp_t e;
            check("ack_onehot", 64'($countones(o_ack)), 64'd1);
            n = int'(o_ack[1]);
            ack_log.push_back(n);
            if (n == 1) n_ack1++;
            if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
               check($sformatf("unexpected_ack_r%0d", n), 64'(o_ack), 64'd0);
            end else begin
               e = (n == 0) ? q0.pop_front() : q1.pop_front();
               check($sformatf("rdata_r%0d", n), 64'(o_rdata), 64'(e.rdata));
               check($sformatf("err_r%0d", n), 64'(o_err), 64'(e.err));
               if (e.we && !e.tmo) n_wr_done++;
            end
         end
      end
   end

   // ---------------- requester side ----------------
   task automatic start_req(input int n, input logic we, input logic [6:0] a,
                            input logic [31:0] d, input bit tmo);
      exp_t e;
      e.we  = we;
      e.tmo = tmo;
      if (tmo) begin
         e.err   = 1'b1;
         e.rdata = '0;
      end else begin
         e.err   = is_err_addr(a);
         e.rdata = we ? 32'h0 : mdl[a[6:2]];
         if (we && !e.err) mdl[a[6:2]] = d;
      end
      if (n == 0) q0.push_back(e); else q1.push_back(e);
      r_we[n] = we; r_addr[n] = a; r_wdata[n] = d; r_req[n] = 1'b1;
      t0[n] = cyc;
   endtask

   task automatic wait_ack(input int n, output int lat);
      bit got = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (o_ack[n]) begin got = 1; break; end
      end
      lat = cyc - t0[n];
      check($sformatf("ack_arrived_r%0d", n), 64'(got), 64'd1);
   endtask

   task automatic drive(input int n, input int count, input bit hold);
      int lat;
      logic [6:0] a;
      for (int k = 0; k < count; k++) begin
         if (!hold) repeat ($urandom_range(3, 0)) @(negedge clk);
         a = {n[0], 4'($urandom_range(15, 0)), 2'b00};
         start_req(n, 1'($urandom_range(1, 0)), a, $urandom, 0);
         wait_ack(n, lat);
         if (!hold || k == count - 1) r_req[n] = 1'b0;
      end
   endtask

   // ---------------- directed and random sequence ----------------
   initial begin
      int lat, tv, b0, a1;
      rst = 1'b1;
      i_vs = 1'b0;
      for (int i = 0; i < 2; i++) begin
         r_req[i] = 0; r_we[i] = 0; r_addr[i] = '0; r_wdata[i] = '0;
      end
      for (int i = 0; i < 32; i++) begin
         mem[i] = $urandom;
         mdl[i] = mem[i];
      end
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'(|{o_ack, o_rdata, o_err, o_timeout, o_axi_awaddr, o_axi_awvalid,
            o_axi_wdata, o_axi_wvalid, o_axi_bready, o_axi_araddr, o_axi_arvalid, o_axi_rready}), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // zero-wait write from requester 0
      start_req(0, 1'b1, 7'h10, 32'hDEADBEEF, 0);
      @(negedge clk);
      check("zw_aw_w_valid", 64'({o_axi_awvalid, o_axi_wvalid}), 64'd3);
      check("zw_awaddr", 64'(o_axi_awaddr), 64'h10);
      check("zw_wdata", 64'(o_axi_wdata), 64'hDEADBEEF);
      wait_ack(0, lat);
      check("zw_latency", 64'(lat), 64'd3);
      r_req[0] = 0;
      @(negedge clk);

      // read from requester 1 with 3 wait states on rvalid
      mem[1] = 32'h12345678; mdl[1] = 32'h12345678;
      cfg_r = 3;
      start_req(1, 1'b0, 7'h04, 32'h0, 0);
      wait_ack(1, lat);
      check("rd_latency", 64'(lat), 64'd6);
      r_req[1] = 0;
      cfg_r = 0;
      @(negedge clk);

      // decoupled write handshake ending in SLVERR
      cfg_w = 2;
      b0 = n_bfire;
      start_req(0, 1'b1, 7'h3C, 32'hCAFEF00D, 0);
      @(negedge clk);
      check("dec_both_valid", 64'({o_axi_awvalid, o_axi_wvalid}), 64'd3);
      @(negedge clk);
      check("dec_aw_first", 64'({o_axi_awvalid, o_axi_wvalid}), 64'd1);
      wait_ack(0, lat);
      check("dec_latency", 64'(lat), 64'd5);
      r_req[0] = 0;
      cfg_w = 0;
      repeat (2) @(negedge clk);
      check("dec_single_b", 64'(n_bfire - b0), 64'd1);

      // response timeout with a slave that never answers B
      b_hang = 1;
      start_req(0, 1'b1, 7'h20, 32'h55AA55AA, 1);
      @(negedge clk);
      check("to_issue", 64'({o_axi_awvalid, o_axi_wvalid}), 64'd3);
      repeat (7) @(negedge clk);
      check("to_still_waiting", 64'(o_axi_bready), 64'd1);
      @(negedge clk);
      check("to_ack", 64'(o_ack), 64'd1);
      check("to_latency", 64'(cyc - t0[0]), 64'd9);
      check("to_axi_quiet", 64'({o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid, o_axi_rready}), 64'd0);
      check("to_flag", 64'(o_timeout), 64'd1);
      r_req[0] = 0;
      repeat (3) @(negedge clk);
      check("to_sticky", 64'(o_timeout), 64'd1);

      // reset mid-transaction
      start_req(0, 1'b0, 7'h08, 32'h0, 0);
      @(negedge clk);
      check("rst_pre_arvalid", 64'(o_axi_arvalid), 64'd1);
      rst = 1'b1;
      #1;
      check("rst_outputs", 64'(|{o_ack, o_rdata, o_err, o_timeout, o_axi_awaddr, o_axi_awvalid,
            o_axi_wdata, o_axi_wvalid, o_axi_bready, o_axi_araddr, o_axi_arvalid, o_axi_rready}), 64'd0);
      q0.delete();
      q1.delete();
      r_req[0] = 0;
      b_hang = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // contention: both requesters hold req for three transactions each
      ack_log.delete();
      fork
         drive(0, 3, 1);
         drive(1, 3, 1);
      join
      @(negedge clk);
      check("cont_count", 64'(ack_log.size()), 64'd6);
      for (int i = 0; i < ack_log.size() && i < 6; i++)
         check($sformatf("cont_grant_%0d", i), 64'(ack_log[i]), 64'(i % 2));

      // randomized traffic with random slave delays
      rand_delays = 1;
      fork
         drive(0, 40, 0);
         drive(1, 40, 0);
      join
      rand_delays = 0;
      repeat (3) @(negedge clk);

`ifdef DSI_CFG_VBLANK_GATE_EN
      a1 = n_ack1;
      start_req(1, 1'b0, 7'h44, 32'h0, 0);
      drive(0, 2, 0);
      repeat (3) @(negedge clk);
      check("vb_blocked", 64'(n_ack1 - a1), 64'd0);
      i_vs = 1'b1;
      tv = cyc;
      wait_ack(1, lat);
      check("vb_latency", 64'(cyc - tv), 64'd5);
      r_req[1] = 0;
      i_vs = 1'b0;
      repeat (3) @(negedge clk);
`else
      a1 = 0;
      tv = 0;
`endif

      check("q0_drained", 64'(q0.size()), 64'd0);
      check("q1_drained", 64'(q1.size()), 64'd0);
      check("b_count", 64'(n_bfire), 64'(n_wr_done));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
